// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
//   Write-back stage of the 3-stage (ID / X / WB) RISC-V core. Registers the
//   X-stage results, exposes the WB-side hazard signals used by the
//   forwarding unit, forms the register-file write data (ALU result, PC+4 or
//   aligned/extended load data from the synchronous DMEM) and owns the tohost
//   CSR plus the cycle / instret counters.
//
// Ports
//   clk, rst          core clock, asynchronous active-high reset
//   stall, flush      hold WB registers / insert a bubble (flush wins)
//   *_X               X-stage instruction fields and results
//   dmem_dout         DMEM read word, valid in the WB cycle
//   cnt_clr           synchronous clear of both counters
//   valid_WB, rd_WB, rf_wen_WB, opcode_WB   registered WB hazard info
//   wb_data           register-file write data (combinational)
//   csr_tohost        tohost CSR
//   cycle_cnt, instret_cnt                  performance counters
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [6:0]  NOP_OPC  = 7'b0010011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_X,
  input  logic [31:0] pc_X,
  input  logic [31:0] alu_X,
  input  logic [4:0]  rd_X,
  input  logic        rf_wen_X,
  input  logic [6:0]  opcode_X,
  input  logic [2:0]  funct3_X,
  input  logic        csr_wen_X,
  input  logic [31:0] csr_wdata_X,
  input  logic [31:0] dmem_dout,
  input  logic        cnt_clr,
  output logic        valid_WB,
  output logic [4:0]  rd_WB,
  output logic        rf_wen_WB,
  output logic [6:0]  opcode_WB,
  output logic [31:0] wb_data,
  output logic [31:0] csr_tohost,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  logic        valid_q,   valid_d;
  logic [4:0]  rd_q,      rd_d;
  logic        rfWen_q,   rfWen_d;
  logic [6:0]  opcode_q,  opcode_d;
  logic [31:0] pc_q,      pc_d;
  logic [31:0] alu_q,     alu_d;
  logic [2:0]  funct3_q,  funct3_d;
  logic [31:0] tohost_q,  tohost_d;
  logic [31:0] cycle_q,   cycle_d;
  logic [31:0] instret_q, instret_d;

  logic        capture;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadData;

  // A capture edge is one that neither flushes nor stalls; the tohost CSR
  // and instret only move on such edges so stalled cycles never double-count.
  assign capture = !flush && !stall;

  // Next-state for the pipeline registers: hold by default, bubble on flush,
  // otherwise take the X slot. Invalid slots are squashed to a NOP with no
  // destination so the forwarding unit never matches against them.
  always_comb begin
    valid_d  = valid_q;
    rd_d     = rd_q;
    rfWen_d  = rfWen_q;
    opcode_d = opcode_q;
    pc_d     = pc_q;
    alu_d    = alu_q;
    funct3_d = funct3_q;
    if (flush) begin
      valid_d  = 1'b0;
      rd_d     = 5'd0;
      rfWen_d  = 1'b0;
      opcode_d = NOP_OPC;
    end else if (!stall) begin
      valid_d  = valid_X;
      rd_d     = valid_X ? rd_X : 5'd0;
      rfWen_d  = rf_wen_X & valid_X;
      opcode_d = valid_X ? opcode_X : NOP_OPC;
      pc_d     = pc_X;
      alu_d    = alu_X;
      funct3_d = funct3_X;
    end
  end

  // Next-state for the CSR and counters; a clear beats any increment.
  always_comb begin
    tohost_d  = tohost_q;
    cycle_d   = cycle_q + 32'd1;
    instret_d = instret_q;
    if (capture && valid_X && csr_wen_X) begin
      tohost_d = csr_wdata_X;
    end
    if (capture && valid_X) begin
      instret_d = instret_q + 32'd1;
    end
    if (cnt_clr) begin
      cycle_d   = 32'd0;
      instret_d = 32'd0;
    end
  end

  // State registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rd_q      <= 5'd0;
      rfWen_q   <= 1'b0;
      opcode_q  <= NOP_OPC;
      pc_q      <= RESET_PC;
      alu_q     <= 32'd0;
      funct3_q  <= 3'd0;
      tohost_q  <= 32'd0;
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      valid_q   <= valid_d;
      rd_q      <= rd_d;
      rfWen_q   <= rfWen_d;
      opcode_q  <= opcode_d;
      pc_q      <= pc_d;
      alu_q     <= alu_d;
      funct3_q  <= funct3_d;
      tohost_q  <= tohost_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  // Load alignment: the DMEM returns a whole little-endian word and the low
  // address bits pick the byte/half. Unknown funct3 values fall back to LW.
  always_comb begin
    loadByte = 8'd0;
    loadHalf = 16'd0;
    loadData = dmem_dout;
    case (alu_q[1:0])
      2'd0:    loadByte = dmem_dout[7:0];
      2'd1:    loadByte = dmem_dout[15:8];
      2'd2:    loadByte = dmem_dout[23:16];
      default: loadByte = dmem_dout[31:24];
    endcase
    loadHalf = alu_q[1] ? dmem_dout[31:16] : dmem_dout[15:0];
    case (funct3_q)
      3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
      3'b100:  loadData = {24'd0, loadByte};
      3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
      3'b101:  loadData = {16'd0, loadHalf};
      default: loadData = dmem_dout;
    endcase
  end

  // Write-back mux, purely from WB registers and the DMEM word so it settles
  // early for the forwarding unit and RF write port.
  always_comb begin
    wb_data = alu_q;
    if (opcode_q == OPC_LOAD) begin
      wb_data = loadData;
    end else if (opcode_q == OPC_JAL || opcode_q == OPC_JALR) begin
      wb_data = pc_q + 32'd4;
    end
  end

  assign valid_WB    = valid_q;
  assign rd_WB       = rd_q;
  assign rf_wen_WB   = rfWen_q;
  assign opcode_WB   = opcode_q;
  assign csr_tohost  = tohost_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
//   Directed self-checking bench for wb_stage: reset values, load alignment,
//   JAL link data, stall hold, flush bubble, counters and the tohost CSR.
// ---------------------------------------------------------------------------
module tb_wb_stage;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] OPC_SYS  = 7'b1110011;
  localparam logic [6:0] OPC_NOP  = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        valid_X;
  logic [31:0] pc_X;
  logic [31:0] alu_X;
  logic [4:0]  rd_X;
  logic        rf_wen_X;
  logic [6:0]  opcode_X;
  logic [2:0]  funct3_X;
  logic        csr_wen_X;
  logic [31:0] csr_wdata_X;
  logic [31:0] dmem_dout;
  logic        cnt_clr;
  logic        valid_WB;
  logic [4:0]  rd_WB;
  logic        rf_wen_WB;
  logic [6:0]  opcode_WB;
  logic [31:0] wb_data;
  logic [31:0] csr_tohost;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  int checkCount = 0;
  int failCount  = 0;

  wb_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .valid_X     (valid_X),
    .pc_X        (pc_X),
    .alu_X       (alu_X),
    .rd_X        (rd_X),
    .rf_wen_X    (rf_wen_X),
    .opcode_X    (opcode_X),
    .funct3_X    (funct3_X),
    .csr_wen_X   (csr_wen_X),
    .csr_wdata_X (csr_wdata_X),
    .dmem_dout   (dmem_dout),
    .cnt_clr     (cnt_clr),
    .valid_WB    (valid_WB),
    .rd_WB       (rd_WB),
    .rf_wen_WB   (rf_wen_WB),
    .opcode_WB   (opcode_WB),
    .wb_data     (wb_data),
    .csr_tohost  (csr_tohost),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one X-stage slot plus control, then advance one clock edge and
  // settle just after it.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                               input logic [4:0] rd, input logic wen, input logic [6:0] opc,
                               input logic [2:0] f3, input logic st, input logic fl,
                               input logic cw, input logic [31:0] cd, input logic clr);
    valid_X     = v;
    pc_X        = pc;
    alu_X       = alu;
    rd_X        = rd;
    rf_wen_X    = wen;
    opcode_X    = opc;
    funct3_X    = f3;
    stall       = st;
    flush       = fl;
    csr_wen_X   = cw;
    csr_wdata_X = cd;
    cnt_clr     = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0; flush = 1'b0; valid_X = 1'b0; pc_X = '0; alu_X = '0; rd_X = '0;
    rf_wen_X = 1'b0; opcode_X = OPC_NOP; funct3_X = '0; csr_wen_X = 1'b0;
    csr_wdata_X = '0; dmem_dout = '0; cnt_clr = 1'b0;
    #12;
    checkOutput("rst_valid",   {31'd0, valid_WB}, 32'd0);
    checkOutput("rst_opcode",  {25'd0, opcode_WB}, 32'h13);
    checkOutput("rst_cycle",   cycle_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load alignment on the word 80FF_1234
    applyStimulus(1, 32'h0, 32'h1003, 5'd3, 1, OPC_LOAD, 3'b000, 0, 0, 0, 32'h0, 0);
    dmem_dout = 32'h80FF_1234;
    #1;
    checkOutput("lb_data",  wb_data, 32'hFFFF_FF80);
    checkOutput("lb_rd",    {27'd0, rd_WB}, 32'd3);
    checkOutput("lb_wen",   {31'd0, rf_wen_WB}, 32'd1);
    applyStimulus(1, 32'h0, 32'h1003, 5'd3, 1, OPC_LOAD, 3'b100, 0, 0, 0, 32'h0, 0);
    checkOutput("lbu_data", wb_data, 32'h0000_0080);
    applyStimulus(1, 32'h0, 32'h1002, 5'd3, 1, OPC_LOAD, 3'b001, 0, 0, 0, 32'h0, 0);
    checkOutput("lh_data",  wb_data, 32'hFFFF_80FF);
    applyStimulus(1, 32'h0, 32'h1002, 5'd3, 1, OPC_LOAD, 3'b101, 0, 0, 0, 32'h0, 0);
    checkOutput("lhu_data", wb_data, 32'h0000_80FF);
    applyStimulus(1, 32'h0, 32'h1001, 5'd3, 1, OPC_LOAD, 3'b000, 0, 0, 0, 32'h0, 0);
    checkOutput("lb_off1",  wb_data, 32'h0000_0012);
    applyStimulus(1, 32'h0, 32'h1003, 5'd3, 1, OPC_LOAD, 3'b010, 0, 0, 0, 32'h0, 0);
    checkOutput("lw_data",  wb_data, 32'h80FF_1234);

    // JAL link value, valid and squashed
    applyStimulus(1, 32'h100, 32'h0, 5'd1, 1, OPC_JAL, 3'b000, 0, 0, 0, 32'h0, 0);
    checkOutput("jal_data", wb_data, 32'h0000_0104);
    checkOutput("jal_rd",   {27'd0, rd_WB}, 32'd1);
    checkOutput("jal_wen",  {31'd0, rf_wen_WB}, 32'd1);
    applyStimulus(0, 32'h100, 32'h0, 5'd1, 1, OPC_JAL, 3'b000, 0, 0, 0, 32'h0, 0);
    checkOutput("inv_wen",  {31'd0, rf_wen_WB}, 32'd0);
    checkOutput("inv_rd",   {27'd0, rd_WB}, 32'd0);
    checkOutput("inv_opc",  {25'd0, opcode_WB}, 32'h13);

    // Clear counters, then capture an ADD and stall three cycles
    applyStimulus(0, 32'h0, 32'h0, 5'd0, 0, OPC_NOP, 3'b000, 0, 0, 0, 32'h0, 1);
    checkOutput("clr_cycle", cycle_cnt, 32'd0);
    applyStimulus(1, 32'h200, 32'h1234, 5'd5, 1, OPC_OP, 3'b000, 0, 0, 0, 32'h0, 0);
    checkOutput("add_data",    wb_data, 32'h0000_1234);
    checkOutput("add_instret", instret_cnt, 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h300, 32'h5555, 5'd9, 1, OPC_OP, 3'b000, 1, 0, 0, 32'h0, 0);
      checkOutput("stall_rd",   {27'd0, rd_WB}, 32'd5);
      checkOutput("stall_data", wb_data, 32'h0000_1234);
    end
    checkOutput("stall_instret", instret_cnt, 32'd1);
    checkOutput("stall_cycle",   cycle_cnt, 32'd4);

    // Flush beats stall on a valid load that also writes tohost
    applyStimulus(1, 32'h400, 32'h2000, 5'd7, 1, OPC_LOAD, 3'b010, 1, 1, 1, 32'hDEAD, 0);
    checkOutput("flush_valid",   {31'd0, valid_WB}, 32'd0);
    checkOutput("flush_wen",     {31'd0, rf_wen_WB}, 32'd0);
    checkOutput("flush_opc",     {25'd0, opcode_WB}, 32'h13);
    checkOutput("flush_instret", instret_cnt, 32'd1);
    checkOutput("flush_tohost",  csr_tohost, 32'd0);
    checkOutput("flush_cycle",   cycle_cnt, 32'd5);

    // Clear on the same edge as a valid capture
    applyStimulus(1, 32'h500, 32'h0, 5'd2, 1, OPC_OP, 3'b000, 0, 0, 0, 32'h0, 1);
    checkOutput("clr_instret", instret_cnt, 32'd0);
    checkOutput("clr_cycle2",  cycle_cnt, 32'd0);

    // csrw tohost, then a stalled csrw must not update it
    applyStimulus(1, 32'h600, 32'h0, 5'd0, 0, OPC_SYS, 3'b001, 0, 0, 1, 32'h1, 0);
    checkOutput("tohost_set",  csr_tohost, 32'd1);
    checkOutput("tohost_inst", instret_cnt, 32'd1);
    applyStimulus(1, 32'h604, 32'h0, 5'd0, 0, OPC_SYS, 3'b001, 1, 0, 1, 32'h2, 0);
    checkOutput("tohost_hold", csr_tohost, 32'd1);
    checkOutput("hold_cycle",  cycle_cnt, 32'd2);

    // Asynchronous reset mid-run, well away from any clock edge
    rst = 1'b1;
    #1;
    checkOutput("arst_valid",   {31'd0, valid_WB}, 32'd0);
    checkOutput("arst_opc",     {25'd0, opcode_WB}, 32'h13);
    checkOutput("arst_cycle",   cycle_cnt, 32'd0);
    checkOutput("arst_instret", instret_cnt, 32'd0);
    checkOutput("arst_tohost",  csr_tohost, 32'd0);
    checkOutput("arst_data",    wb_data, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
